// File: rtl/grn_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : grn_pkg
//  Description : Shared definitions for the gene-regulatory-network node
//                generator: activator combine-mode encodings, parameter
//                range limits and the Boolean node-update function.
//  Revision    : 1.0 - initial release
// ============================================================================
package grn_pkg;

    // Activator combine mode.
    typedef enum logic {
        GRN_MODE_AND = 1'b0,
        GRN_MODE_OR  = 1'b1
    } grn_mode_e;

    // Legal parameter ranges.
    localparam int c_GRN_NUM_IN_MIN      = 1;
    localparam int c_GRN_NUM_IN_MAX      = 16;
    localparam int c_GRN_NUM_STREAMS_MIN = 1;
    localparam int c_GRN_NUM_STREAMS_MAX = 32;

    // Width of the optional per-stream transition counter.
    localparam int c_GRN_TRANS_W         = 8;

    // Node update rule on zero-extended operands. Padding bits carry zero
    // masks, so they are neutral for both the AND and OR activator forms.
    // A bit selected by both masks is removed from the activator set.
    function automatic logic grn_eval(
        input logic [c_GRN_NUM_IN_MAX-1:0] bits,
        input logic [c_GRN_NUM_IN_MAX-1:0] act_mask,
        input logic [c_GRN_NUM_IN_MAX-1:0] inh_mask,
        input logic                        mode
    );
        logic [c_GRN_NUM_IN_MAX-1:0] act_sel;
        logic                        act_term;
        logic                        inh_term;
        act_sel  = act_mask & ~inh_mask;
        inh_term = |(bits & inh_mask);
        if (act_sel == '0) begin
            act_term = 1'b1;
        end else if (mode == GRN_MODE_OR) begin
            act_term = |(bits & act_sel);
        end else begin
            act_term = &(bits | ~act_sel);
        end
        return act_term & ~inh_term;
    endfunction

endpackage : grn_pkg
`default_nettype wire

// File: rtl/grn_node_lane.sv
`default_nettype none
// ============================================================================
//  Module      : grn_node_lane
//  Description : One node-state stream: update-period counter, registered
//                state, one-cycle changed pulse and, when the macro
//                GRN_NODE_TRANS_CNT_EN is defined, a saturating 8-bit count
//                of state transitions.
//  Ports       : clk, rst (async, active-high), reset_nos (sync re-init),
//                init_state, start, in_bits[NUM_IN], act_mask, inh_mask,
//                mode, delay_cfg -> state, changed [, trans_cnt]
//  Revision    : 1.0 - initial release
// ============================================================================
module grn_node_lane #(
    parameter int NUM_IN  = 2,
    parameter int DELAY_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               reset_nos,
    input  logic               init_state,
    input  logic               start,
    input  logic [NUM_IN-1:0]  in_bits,
    input  logic [NUM_IN-1:0]  act_mask,
    input  logic [NUM_IN-1:0]  inh_mask,
    input  logic               mode,
    input  logic [DELAY_W-1:0] delay_cfg,
    output logic               state,
    output logic               changed
`ifdef GRN_NODE_TRANS_CNT_EN
    ,
    output logic [7:0]         trans_cnt
`endif
);
    import grn_pkg::*;

    logic               w_next;
    logic               state_q,   state_d;
    logic               changed_q, changed_d;
    logic [DELAY_W-1:0] cnt_q,     cnt_d;

    assign w_next = grn_eval(c_GRN_NUM_IN_MAX'(in_bits),
                             c_GRN_NUM_IN_MAX'(act_mask),
                             c_GRN_NUM_IN_MAX'(inh_mask),
                             mode);

    // reset_nos wins over a coincident strobe. A strobe with the counter at
    // zero updates and reloads it from delay_cfg; any other strobe only
    // counts down, so delay_cfg changes are picked up at the next reload.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        changed_d = 1'b0;
        if (reset_nos) begin
            state_d = init_state;
            cnt_d   = '0;
        end else if (start) begin
            if (cnt_q == '0) begin
                state_d   = w_next;
                cnt_d     = delay_cfg;
                changed_d = w_next ^ state_q;
            end else begin
                cnt_d = cnt_q - DELAY_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= 1'b0;
            changed_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            changed_q <= changed_d;
            cnt_q     <= cnt_d;
        end
    end

    assign state   = state_q;
    assign changed = changed_q;

`ifdef GRN_NODE_TRANS_CNT_EN
    logic [7:0] trans_cnt_q, trans_cnt_d;

    // Counts on the same edge that raises changed, so the count already
    // includes a transition while its pulse is visible.
    always_comb begin
        trans_cnt_d = trans_cnt_q;
        if (reset_nos) begin
            trans_cnt_d = '0;
        end else if (changed_d && (trans_cnt_q != 8'hFF)) begin
            trans_cnt_d = trans_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            trans_cnt_q <= '0;
        end else begin
            trans_cnt_q <= trans_cnt_d;
        end
    end

    assign trans_cnt = trans_cnt_q;
`endif

endmodule : grn_node_lane
`default_nettype wire

// File: rtl/grn_node_gen.sv
`default_nettype none
// ============================================================================
//  Module      : grn_node_gen
//  Description : Array of NUM_STREAMS independent Boolean network nodes
//                sharing one activator/inhibitor configuration. Each stream
//                updates on its own start strobe, with delay_cfg strobes
//                skipped between updates.
//                Optional feature: define GRN_NODE_TRANS_CNT_EN to add the
//                trans_cnt output (8-bit saturating transition count per
//                stream).
//  Ports       : clk, rst (async, active-high), reset_nos, init_state,
//                start, in_bits[NUM_STREAMS*NUM_IN], act_mask, inh_mask,
//                mode, delay_cfg -> state, changed [, trans_cnt]
//  Revision    : 1.0 - initial release
// ============================================================================
module grn_node_gen #(
    parameter int NUM_IN      = 2,
    parameter int NUM_STREAMS = 2,
    parameter int DELAY_W     = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          reset_nos,
    input  logic [NUM_STREAMS-1:0]        init_state,
    input  logic [NUM_STREAMS-1:0]        start,
    input  logic [NUM_STREAMS*NUM_IN-1:0] in_bits,
    input  logic [NUM_IN-1:0]             act_mask,
    input  logic [NUM_IN-1:0]             inh_mask,
    input  logic                          mode,
    input  logic [DELAY_W-1:0]            delay_cfg,
    output logic [NUM_STREAMS-1:0]        state,
    output logic [NUM_STREAMS-1:0]        changed
`ifdef GRN_NODE_TRANS_CNT_EN
    ,
    output logic [NUM_STREAMS*8-1:0]      trans_cnt
`endif
);
    import grn_pkg::*;

    for (genvar k = 0; k < NUM_STREAMS; k++) begin : g_lane
        grn_node_lane #(
            .NUM_IN  (NUM_IN),
            .DELAY_W (DELAY_W)
        ) u_lane (
            .clk        (clk),
            .rst        (rst),
            .reset_nos  (reset_nos),
            .init_state (init_state[k]),
            .start      (start[k]),
            .in_bits    (in_bits[k*NUM_IN +: NUM_IN]),
            .act_mask   (act_mask),
            .inh_mask   (inh_mask),
            .mode       (mode),
            .delay_cfg  (delay_cfg),
            .state      (state[k]),
            .changed    (changed[k])
`ifdef GRN_NODE_TRANS_CNT_EN
            ,
            .trans_cnt  (trans_cnt[k*8 +: 8])
`endif
        );
    end

endmodule : grn_node_gen
`default_nettype wire

// File: tb/tb_grn_node_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_grn_node_gen
//  Description : Directed self-checking bench for grn_node_gen
//                (NUM_IN=2, NUM_STREAMS=2, DELAY_W=4). Trans-count checks
//                are present when GRN_NODE_TRANS_CNT_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_grn_node_gen;
    localparam int NUM_IN      = 2;
    localparam int NUM_STREAMS = 2;
    localparam int DELAY_W     = 4;

    logic                          clk = 1'b0;
    logic                          rst;
    logic                          reset_nos;
    logic [NUM_STREAMS-1:0]        init_state;
    logic [NUM_STREAMS-1:0]        start;
    logic [NUM_STREAMS*NUM_IN-1:0] in_bits;
    logic [NUM_IN-1:0]             act_mask;
    logic [NUM_IN-1:0]             inh_mask;
    logic                          mode;
    logic [DELAY_W-1:0]            delay_cfg;
    logic [NUM_STREAMS-1:0]        state;
    logic [NUM_STREAMS-1:0]        changed;
`ifdef GRN_NODE_TRANS_CNT_EN
    logic [NUM_STREAMS*8-1:0]      trans_cnt;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    grn_node_gen #(
        .NUM_IN      (NUM_IN),
        .NUM_STREAMS (NUM_STREAMS),
        .DELAY_W     (DELAY_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .reset_nos  (reset_nos),
        .init_state (init_state),
        .start      (start),
        .in_bits    (in_bits),
        .act_mask   (act_mask),
        .inh_mask   (inh_mask),
        .mode       (mode),
        .delay_cfg  (delay_cfg),
        .state      (state),
        .changed    (changed)
`ifdef GRN_NODE_TRANS_CNT_EN
        ,
        .trans_cnt  (trans_cnt)
`endif
    );

    // Advance to 1 ns after the next rising edge.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Network re-init with the given initial state.
    task automatic nos(input logic [1:0] init);
        reset_nos  = 1'b1;
        init_state = init;
        start      = 2'b00;
        tick();
        reset_nos  = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; reset_nos = 1'b0; init_state = '0; start = '0;
        in_bits = '0; act_mask = 2'b11; inh_mask = 2'b00; mode = 1'b0;
        delay_cfg = '0;
        #12;
        checks++;
        if (state !== 2'b00) begin
            failures++; $display("FAIL reset_state got=%b exp=00", state);
        end
        checks++;
        if (changed !== 2'b00) begin
            failures++; $display("FAIL reset_changed got=%b exp=00", changed);
        end
        @(negedge clk);
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic;
        nos(2'b00);
        act_mask = 2'b11; inh_mask = 2'b00; mode = 1'b0; delay_cfg = 4'd0;
        in_bits = 4'b0011; start = 2'b01;
        tick();
        start = 2'b00;
        checks++;
        if (state !== 2'b01) begin
            failures++; $display("FAIL basic_state got=%b exp=01", state);
        end
        checks++;
        if (changed !== 2'b01) begin
            failures++; $display("FAIL basic_changed got=%b exp=01", changed);
        end
        tick();
        checks++;
        if (changed !== 2'b00 || state !== 2'b01) begin
            failures++;
            $display("FAIL basic_pulse_end got=%b/%b exp=01/00", state, changed);
        end
    endtask

    task automatic test_modes;
        nos(2'b10);
        act_mask = 2'b11; inh_mask = 2'b00; delay_cfg = 4'd0;
        // OR: s0 in=01 -> 1, s1 in=00 -> 0
        mode = 1'b1; in_bits = 4'b0001; start = 2'b11;
        tick();
        checks++;
        if (state !== 2'b01 || changed !== 2'b11) begin
            failures++;
            $display("FAIL mode_or got=%b/%b exp=01/11", state, changed);
        end
        // AND: s0 in=01 -> 0, s1 in=11 -> 1
        mode = 1'b0; in_bits = 4'b1101;
        tick();
        checks++;
        if (state !== 2'b10 || changed !== 2'b11) begin
            failures++;
            $display("FAIL mode_and got=%b/%b exp=10/11", state, changed);
        end
        // Empty activator set yields 1 on s0
        act_mask = 2'b00; in_bits = 4'b0000; start = 2'b01;
        tick();
        start = 2'b00;
        checks++;
        if (state !== 2'b11 || changed !== 2'b01) begin
            failures++;
            $display("FAIL empty_act got=%b/%b exp=11/01", state, changed);
        end
    endtask

    task automatic test_inhibit;
        nos(2'b01);
        act_mask = 2'b01; inh_mask = 2'b11; mode = 1'b0; delay_cfg = 4'd0;
        in_bits = 4'b0011; start = 2'b01;
        tick();
        checks++;
        if (state !== 2'b00 || changed !== 2'b01) begin
            failures++;
            $display("FAIL inhibit_wins got=%b/%b exp=00/01", state, changed);
        end
        in_bits = 4'b0001;
        tick();
        checks++;
        if (state !== 2'b00 || changed !== 2'b00) begin
            failures++;
            $display("FAIL both_mask_inh got=%b/%b exp=00/00", state, changed);
        end
        inh_mask = 2'b10;
        tick();
        start = 2'b00;
        checks++;
        if (state !== 2'b01 || changed !== 2'b01) begin
            failures++;
            $display("FAIL act_only got=%b/%b exp=01/01", state, changed);
        end
    endtask

    task automatic test_delay;
        logic [1:0] ins   [9] = '{2'b11, 2'b00, 2'b00, 2'b11, 2'b11,
                                  2'b00, 2'b00, 2'b00, 2'b00};
        logic       exp_s [9] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1,
                                  1'b1, 1'b1, 1'b1, 1'b0};
        logic       prev;
        nos(2'b00);
        act_mask = 2'b11; inh_mask = 2'b00; mode = 1'b0; delay_cfg = 4'd1;
        prev = 1'b0;
        for (int i = 0; i < 9; i++) begin
            if (i == 4) delay_cfg = 4'd3;
            if (i == 5) delay_cfg = 4'd0;
            in_bits = {2'b11, ins[i]};
            start   = 2'b01;
            tick();
            start   = 2'b00;
            checks++;
            if (state !== {1'b0, exp_s[i]} ||
                changed !== {1'b0, (exp_s[i] != prev)}) begin
                failures++;
                $display("FAIL delay_strobe%0d got=%b/%b exp=%b/%b", i + 1,
                         state, changed, {1'b0, exp_s[i]},
                         {1'b0, (exp_s[i] != prev)});
            end
            prev = exp_s[i];
            tick();
        end
    endtask

    task automatic test_priority;
        delay_cfg = 4'd2;
        nos(2'b00);
        act_mask = 2'b11; inh_mask = 2'b00; mode = 1'b0; in_bits = 4'b0000;
        reset_nos = 1'b1; init_state = 2'b01; start = 2'b01;
        tick();
        reset_nos = 1'b0;
        checks++;
        if (state !== 2'b01 || changed !== 2'b00) begin
            failures++;
            $display("FAIL nos_priority got=%b/%b exp=01/00", state, changed);
        end
        // Counter cleared by the re-init: this strobe updates immediately.
        tick();
        start = 2'b00;
        checks++;
        if (state !== 2'b00 || changed !== 2'b01) begin
            failures++;
            $display("FAIL nos_cnt_clear got=%b/%b exp=00/01", state, changed);
        end
    endtask

    task automatic test_async_rst;
        nos(2'b00);
        act_mask = 2'b11; inh_mask = 2'b00; mode = 1'b0; delay_cfg = 4'd3;
        in_bits = 4'b0011; start = 2'b01;
        tick();
        start = 2'b00;
        checks++;
        if (state !== 2'b01 || changed !== 2'b01) begin
            failures++;
            $display("FAIL pre_rst got=%b/%b exp=01/01", state, changed);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (state !== 2'b00 || changed !== 2'b00) begin
            failures++;
            $display("FAIL async_rst got=%b/%b exp=00/00", state, changed);
        end
`ifdef GRN_NODE_TRANS_CNT_EN
        checks++;
        if (trans_cnt !== 16'h0000) begin
            failures++;
            $display("FAIL rst_trans_cnt got=%h exp=0000", trans_cnt);
        end
`endif
        @(negedge clk);
        rst = 1'b0;
        tick();
        // Counter was 3 before rst; a discarded count lets this update at once.
        start = 2'b01;
        tick();
        start = 2'b00;
        checks++;
        if (state !== 2'b01 || changed !== 2'b01) begin
            failures++;
            $display("FAIL post_rst_update got=%b/%b exp=01/01", state, changed);
        end
    endtask

`ifdef GRN_NODE_TRANS_CNT_EN
    task automatic test_trans_cnt;
        nos(2'b00);
        act_mask = 2'b11; inh_mask = 2'b00; mode = 1'b0; delay_cfg = 4'd0;
        for (int i = 0; i < 300; i++) begin
            in_bits = (i % 2 == 0) ? 4'b0011 : 4'b0000;
            start   = 2'b01;
            tick();
            if (i == 2) begin
                checks++;
                if (trans_cnt[7:0] !== 8'd3) begin
                    failures++;
                    $display("FAIL trans_cnt_3 got=%0d exp=3", trans_cnt[7:0]);
                end
            end
        end
        start = 2'b00;
        checks++;
        if (trans_cnt !== 16'h00FF) begin
            failures++;
            $display("FAIL trans_cnt_sat got=%h exp=00ff", trans_cnt);
        end
        nos(2'b00);
        checks++;
        if (trans_cnt !== 16'h0000) begin
            failures++;
            $display("FAIL trans_cnt_nos got=%h exp=0000", trans_cnt);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_modes();
        test_inhibit();
        test_delay();
        test_priority();
        test_async_rst();
`ifdef GRN_NODE_TRANS_CNT_EN
        test_trans_cnt();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_grn_node_gen
`default_nettype wire

// File: doc/grn_node_gen.md
GRN_NODE_GEN -- requirements
Module: grn_node_gen

Interface
REQ-001 SHALL have parameter NUM_IN, default 2: number of regulator inputs per stream, 1..16.
REQ-002 SHALL have parameter NUM_STREAMS, default 2: number of independent state streams, 1..32.
REQ-003 SHALL have parameter DELAY_W, default 4: width of the update-period counter.
REQ-004 SHALL have one clock and one reset, the reset asynchronous and active-high: clk, in, 1, rising-edge clock.
REQ-005 SHALL have rst, in, 1, asynchronous active-high reset.
REQ-006 SHALL have reset_nos, in, 1, synchronous network re-init.
REQ-007 SHALL have init_state, in, NUM_STREAMS, per-stream value loaded on reset_nos.
REQ-008 SHALL have start, in, NUM_STREAMS, per-stream update strobe.
REQ-009 SHALL have in_bits, in, NUM_STREAMS*NUM_IN, regulator values; stream k occupies bits [k*NUM_IN +: NUM_IN].
REQ-010 SHALL have act_mask, in, NUM_IN, activator select.
REQ-011 SHALL have inh_mask, in, NUM_IN, inhibitor select.
REQ-012 SHALL have mode, in, 1, activator combine: 0 = AND, 1 = OR.
REQ-013 SHALL have delay_cfg, in, DELAY_W, number of start strobes skipped between updates.
REQ-014 SHALL have state, out, NUM_STREAMS, registered node state per stream.
REQ-015 SHALL have changed, out, NUM_STREAMS, one-cycle pulse when an update flips the state.

Function
REQ-016 SHALL compute act_term as AND (mode=0) or OR (mode=1) over inputs with act_mask=1 and inh_mask=0; an empty activator set SHALL yield 1.
REQ-017 SHALL compute inh_term as the OR over inputs with inh_mask=1 (an empty set yields 0); a bit set in both masks SHALL count as an inhibitor only.
REQ-018 SHALL define next_k = act_term & ~inh_term, evaluated on stream k's in_bits in the cycle its update occurs.
REQ-019 SHALL keep a per-stream counter cnt_k; on reset_nos it SHALL load state_k <= init_state[k] and cnt_k <= 0, and clear changed_k.
REQ-020 On start[k] with cnt_k==0, SHALL load state_k <= next_k and cnt_k <= delay_cfg, one-cycle latency; otherwise SHALL decrement cnt_k and leave state_k unchanged.
REQ-021 delay_cfg=0 SHALL update on every strobe; delay_cfg=1 SHALL update on the 1st, 3rd, 5th... strobe after reset_nos.
REQ-022 A change to delay_cfg SHALL take effect only at the next counter reload.
REQ-023 reset_nos SHALL take priority over a coincident start.
REQ-024 changed_k SHALL be high for exactly the cycle after an update where next_k != old state_k, and low otherwise.
REQ-025 Streams SHALL be fully independent; no start strobe SHALL affect any other stream.

Reset
REQ-026 rst SHALL asynchronously force state, changed, all counters and the optional transition counts to 0, independent of clk.
REQ-027 rst asserted mid-delay SHALL discard the count; the first start after release and reset_nos SHALL update immediately.

Configuration
REQ-028 With GRN_NODE_TRANS_CNT_EN defined, the block SHALL add output trans_cnt (NUM_STREAMS*8), a per-stream 8-bit count of changed pulses that saturates at 255 and is cleared by reset_nos and rst.
REQ-029 Without GRN_NODE_TRANS_CNT_EN, trans_cnt and its logic SHALL be absent.

Structure
REQ-030 Package grn_pkg SHALL hold the mode encodings (GRN_MODE_AND=0, GRN_MODE_OR=1) and the parameter-range limits.
REQ-031 One sub-module, grn_node_lane (a single stream: counter, state, changed and optional trans_cnt), SHALL be instantiated NUM_STREAMS times by a generate loop.

Verification
REQ-032 NUM_IN=2, act_mask=11, inh_mask=00, mode=0, delay_cfg=0, in=11, start -> state=1 next cycle, changed=1 for one cycle.
REQ-033 delay_cfg=1 after reset_nos (init 0), in=11, four start strobes -> state updates on strobes 1 and 3 only; changed pulses once.
REQ-034 act_mask=01, inh_mask=11, in=11 -> inhibitor wins, state=0; then in=01 -> state=0, since bit0 counts as an inhibitor only.
REQ-035 reset_nos and start in the same cycle, init_state=1 -> state=1, counter=0, no changed pulse.
REQ-036 rst asserted between clk edges with cnt=3 -> state, changed and cnt read 0 immediately; trans_cnt=0 when GRN_NODE_TRANS_CNT_EN is defined.
REQ-037 GRN_NODE_TRANS_CNT_EN defined, 300 toggling updates -> trans_cnt saturates at 255.
